// File: rtl/dict_stream_decoder.sv
// Receive-side dictionary decoder: rebuilds the compressor's dictionary from
// literal/reference tokens and emits the original words in order.
module dict_stream_decoder #(
    parameter int DATA_W = 80,
    parameter int IDX_W  = 8,
    parameter int ERR_CW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              tok_valid,
    output logic              tok_ready,
    input  logic              tok_literal,
    input  logic [IDX_W-1:0]  tok_index,
    input  logic [DATA_W-1:0] tok_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic [1:0]        out_resp,
    output logic [IDX_W-1:0]  entries,
    output logic [ERR_CW-1:0] err_count
);

    typedef enum logic [1:0] {
        RESP_NONE = 2'b00,
        RESP_LIT  = 2'b01,
        RESP_HIT  = 2'b10,
        RESP_ERR  = 2'b11
    } resp_e;

    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_W-1:0] r_dict [0:DEPTH-1];

    logic              r_outValid;
    logic [DATA_W-1:0] r_outData;
    logic [IDX_W-1:0]  r_outIndex;
    resp_e             r_outResp;
    logic [IDX_W-1:0]  r_entries;
    logic [ERR_CW-1:0] r_errCount;

    logic w_tokReady;
    logic w_accept;
    logic w_full;
    logic w_hit;
    logic w_store;
    logic w_err;

    assign w_tokReady = !clr && (!r_outValid || out_ready);
    assign w_accept   = tok_valid && w_tokReady;
    // The all-ones index is never written, so "full" means entries reached it.
    assign w_full     = (r_entries == {IDX_W{1'b1}});
    assign w_hit      = (tok_index < r_entries);
    assign w_store    = w_accept && tok_literal && !w_full;
    assign w_err      = w_accept && (tok_literal ? w_full : !w_hit);

    // Dictionary has no reset: the entries bound hides stale contents.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_dict[r_entries] <= tok_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outIndex <= '0;
            r_outResp  <= RESP_NONE;
            r_entries  <= '0;
            r_errCount <= '0;
        end else begin
            if (w_accept) begin
                r_outValid <= 1'b1;
                if (tok_literal) begin
                    r_outData <= tok_data;
                    if (w_full) begin
                        r_outIndex <= '0;
                        r_outResp  <= RESP_ERR;
                    end else begin
                        r_outIndex <= r_entries;
                        r_outResp  <= RESP_LIT;
                    end
                end else if (w_hit) begin
                    r_outData  <= r_dict[tok_index];
                    r_outIndex <= tok_index;
                    r_outResp  <= RESP_HIT;
                end else begin
                    r_outData  <= '0;
                    r_outIndex <= '0;
                    r_outResp  <= RESP_ERR;
                end
            end else if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end

            // A flush only empties the dictionary; a pending beat still drains.
            if (clr) begin
                r_entries <= '0;
            end else if (w_store) begin
                r_entries <= r_entries + IDX_W'(1);
            end

            if (w_err && (r_errCount != {ERR_CW{1'b1}})) begin
                r_errCount <= r_errCount + ERR_CW'(1);
            end
        end
    end

    assign tok_ready = w_tokReady;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_index = r_outIndex;
    assign out_resp  = r_outResp;
    assign entries   = r_entries;
    assign err_count = r_errCount;

endmodule
